anim_scheduler: RTL and testbench

ANIM_SCHEDULER -- requirements
Module: anim_scheduler

---
 rtl/anim_scheduler.sv | 165 ++++++++++++++++
 tb/tb_anim_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_scheduler.sv
// anim_scheduler
//   Sequences per-frame update strobes across N_OBJ animated objects. An
//   end-of-frame pulse (i_animate) starts a pass over the objects. Each
//   enabled object gets a one-cycle strobe, and the scheduler then waits for
//   that object's i_done pulse, or gives up after TIMEOUT cycles. Disabled
//   objects are skipped. The scheduler can be paused, and while paused it can
//   be single-stepped one frame at a time.
//
// Parameters
//   N_OBJ    number of objects sequenced (>= 1)
//   TIMEOUT  maximum WAIT cycles per object (1..255)
//   FRAME_W  width of the completed-frame counter
//
// Ports
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_animate  one-cycle end-of-frame pulse
//   i_pause    level; high suppresses frame starts
//   i_step     pulse; while paused, arms exactly one frame
//   i_en       per-object enable, sampled while issuing that object
//   i_done     per-object update-complete pulse
//   i_clr      pulse; clears the sticky flags
//   o_ani_stb  one-hot, one-cycle update strobe
//   o_busy     high whenever a frame is in progress
//   o_frame    count of completed frames (wraps)
//   o_overrun  sticky: i_animate arrived while busy
//   o_timeout  sticky: an object missed its i_done deadline
module anim_scheduler #(
    parameter int unsigned N_OBJ   = 3,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned FRAME_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_animate,
    input  logic               i_pause,
    input  logic               i_step,
    input  logic [N_OBJ-1:0]   i_en,
    input  logic [N_OBJ-1:0]   i_done,
    input  logic               i_clr,
    output logic [N_OBJ-1:0]   o_ani_stb,
    output logic               o_busy,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_overrun,
    output logic               o_timeout
);

    localparam int unsigned      IDX_W      = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_OBJ - 1);
    localparam logic [7:0]       TIMER_LOAD = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       timer;
    logic             step_armed;

    logic             cur_en;
    logic             cur_done;
    logic             start;
    logic             overrun_set;
    logic             timeout_set;

    // Select the enable and done bits of the object currently addressed.
    always_comb begin
        cur_en   = 1'b0;
        cur_done = 1'b0;
        for (int unsigned k = 0; k < N_OBJ; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_en   = i_en[k];
                cur_done = i_done[k];
            end
        end
    end

    // A frame starts only from IDLE, and only when unpaused or when a step
    // is armed. A pulse that arrives while busy is dropped and flagged.
    always_comb begin
        start       = (state == IDLE) && i_animate && (!i_pause || step_armed);
        overrun_set = (state != IDLE) && i_animate;
        timeout_set = (state == WAIT) && !cur_done && (timer == 8'd1);
    end

    // The strobe decodes from the current state and the live i_en, because
    // the enable is defined as sampled in the ISSUE cycle itself. A registered
    // strobe would have to look ahead at i_en one cycle early.
    always_comb begin
        o_ani_stb = '0;
        if (state == ISSUE) begin
            for (int unsigned k = 0; k < N_OBJ; k++) begin
                if (idx == IDX_W'(k)) begin
                    o_ani_stb[k] = i_en[k];
                end
            end
        end
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            idx        <= '0;
            timer      <= '0;
            step_armed <= 1'b0;
            o_frame    <= '0;
            o_overrun  <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            // Any frame start consumes an armed step. A step seen while
            // paused (re)arms it.
            step_armed <= (i_step && i_pause) || (step_armed && !start);

            // A set event in the same cycle as a clear wins.
            o_overrun  <= overrun_set || (o_overrun && !i_clr);
            o_timeout  <= timeout_set || (o_timeout && !i_clr);

            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_en) begin
                        timer <= TIMER_LOAD;
                        state <= WAIT;
                    end else begin
                        state <= NEXT;
                    end
                end
                WAIT: begin
                    if (cur_done) begin
                        state <= NEXT;
                    end else begin
                        timer <= timer - 8'd1;
                        if (timer == 8'd1) begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (idx != LAST_IDX) begin
                        idx   <= idx + 1'b1;
                        state <= ISSUE;
                    end else begin
                        o_frame <= o_frame + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anim_scheduler.sv
// tb_anim_scheduler
//   Self-checking bench for anim_scheduler (N_OBJ=3, TIMEOUT=4, FRAME_W=4).
//   For each frame, the expected strobe timeline is computed from the
//   per-object enable and done-delay choices: an enabled object occupies
//   min(delay, TIMEOUT) + 2 cycles, and a disabled object occupies 2 cycles.
//   Every cycle, the bench compares the DUT against that timeline plus
//   event-based flag and frame-count models.
module tb_anim_scheduler;

    localparam int unsigned N_OBJ = 3;
    localparam int          TO    = 4;
    localparam int unsigned FW    = 4;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_animate;
    logic             i_pause;
    logic             i_step;
    logic [N_OBJ-1:0] i_en;
    logic [N_OBJ-1:0] i_done;
    logic             i_clr;
    logic [N_OBJ-1:0] o_ani_stb;
    logic             o_busy;
    logic [FW-1:0]    o_frame;
    logic             o_overrun;
    logic             o_timeout;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state
    int unsigned frame_m = 0;
    bit          ov_m    = 1'b0;
    bit          to_m    = 1'b0;
    bit          step_m  = 1'b0;
    int          dl [N_OBJ];

    anim_scheduler #(
        .N_OBJ   (N_OBJ),
        .TIMEOUT (TO),
        .FRAME_W (FW)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_animate (i_animate),
        .i_pause   (i_pause),
        .i_step    (i_step),
        .i_en      (i_en),
        .i_done    (i_done),
        .i_clr     (i_clr),
        .o_ani_stb (o_ani_stb),
        .o_busy    (o_busy),
        .o_frame   (o_frame),
        .o_overrun (o_overrun),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        check_eq({tag, "_overrun"}, 32'(o_overrun), 32'(ov_m));
        check_eq({tag, "_timeout"}, 32'(o_timeout), 32'(to_m));
    endtask

    // Offer one end-of-frame pulse and follow the whole frame cycle by cycle.
    // inj_ovr adds a second i_animate during the busy window; clr_ovr places
    // an i_clr on that same cycle; pause_mid raises i_pause mid-frame.
    task automatic run_frame(input logic [2:0] en, input bit inj_ovr,
                             input bit clr_ovr, input bit pause_mid);
        logic [2:0] exp_stb  [32];
        logic [2:0] done_sch [32];
        bit         to_set   [32];
        int         owner    [32];
        int         c, w, len, ovr_at;
        bit         start, exp_busy, do_ovr;
        logic [2:0] noise;

        for (int i = 0; i < 32; i++) begin
            exp_stb[i]  = '0;
            done_sch[i] = '0;
            to_set[i]   = 1'b0;
            owner[i]    = -1;
        end

        start = !i_pause || step_m;
        len   = 4;
        if (start) begin
            step_m = 1'b0;
            c = 1;
            for (int k = 0; k < int'(N_OBJ); k++) begin
                if (en[k]) begin
                    exp_stb[c] = 3'(1 << k);
                    w = (dl[k] <= TO) ? dl[k] : TO;
                    if (dl[k] <= TO) done_sch[c + dl[k]][k] = 1'b1;
                    else             to_set[c + TO] = 1'b1;
                    for (int j = c; j <= c + w + 1; j++) owner[j] = k;
                    c += w + 2;
                end else begin
                    owner[c]     = k;
                    owner[c + 1] = k;
                    c += 2;
                end
            end
            len = c;
        end
        do_ovr = inj_ovr && start;
        ovr_at = do_ovr ? int'($urandom_range(2, len - 1)) : -1;

        for (int off = 0; off <= len; off++) begin
            // Unrelated i_done bits are noise the DUT must ignore.
            noise = 3'($urandom);
            if (owner[off] >= 0) noise[owner[off]] = 1'b0;
            i_en      = en;
            i_done    = done_sch[off] | noise;
            i_animate = (off == 0) || (off == ovr_at);
            i_clr     = clr_ovr && (off == ovr_at);
            if (pause_mid && off == 2) i_pause = 1'b1;
            exp_busy = start && off >= 1 && off < len;

            @(negedge i_clk);
            check_eq("stb",   32'(o_ani_stb), 32'(exp_stb[off]));
            check_eq("busy",  32'(o_busy),    32'(exp_busy));
            check_eq("frame", 32'(o_frame),
                     (start && off == len) ? (frame_m + 1) % (1 << FW) : frame_m);
            check_flags("frm");

            ov_m = (i_animate && exp_busy) || (ov_m && !i_clr);
            to_m = to_set[off] || (to_m && !i_clr);
            tick();
        end
        if (start) frame_m = (frame_m + 1) % (1 << FW);
        i_animate = 1'b0;
        i_done    = '0;
        i_clr     = 1'b0;
    endtask

    task automatic pulse_step();
        i_step = 1'b1;
        @(negedge i_clk);
        check_eq("step_busy", 32'(o_busy), 32'd0);
        if (i_pause) step_m = 1'b1;
        tick();
        i_step = 1'b0;
    endtask

    task automatic clear_flags();
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        ov_m  = 1'b0;
        to_m  = 1'b0;
        @(negedge i_clk);
        check_flags("clr");
        tick();
    endtask

    task automatic random_frame(input bit allow_pause);
        logic [2:0] en;
        en = 3'($urandom);
        for (int k = 0; k < int'(N_OBJ); k++) dl[k] = int'($urandom_range(1, TO + 1));
        i_pause = allow_pause && ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) pulse_step();
        run_frame(en, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 1'b0);
        i_pause = 1'b0;
        if ($urandom_range(0, 3) == 0) clear_flags();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1; i_animate = 1'b0; i_pause = 1'b0; i_step = 1'b0;
        i_en = '1; i_done = '0; i_clr = 1'b0;
        repeat (3) tick();
        @(negedge i_clk);
        check_eq("rst_stb",   32'(o_ani_stb), 32'd0);
        check_eq("rst_busy",  32'(o_busy),    32'd0);
        check_eq("rst_frame", 32'(o_frame),   32'd0);
        check_flags("rst");
        tick();
        i_rst = 1'b0;
        tick();

        // All enabled, done two cycles after each strobe: strobes at t+1, t+5, t+9.
        dl = '{2, 2, 2};
        run_frame(3'b111, 1'b0, 1'b0, 1'b0);
        // Middle object disabled.
        dl = '{1, 3, 2};
        run_frame(3'b101, 1'b0, 1'b0, 1'b0);
        // Object 1 never completes, so it times out and object 2 still runs.
        dl = '{2, 9, 1};
        run_frame(3'b111, 1'b0, 1'b0, 1'b0);
        clear_flags();
        // Done on the very last WAIT cycle beats the timeout.
        dl = '{TO, 1, TO};
        run_frame(3'b111, 1'b0, 1'b0, 1'b0);
        // Overrun during a frame, then a set that collides with a clear.
        dl = '{2, 2, 2};
        run_frame(3'b111, 1'b1, 1'b0, 1'b0);
        clear_flags();
        run_frame(3'b011, 1'b1, 1'b1, 1'b0);
        clear_flags();
        // Pause and single-step.
        i_pause = 1'b1;
        run_frame(3'b111, 1'b0, 1'b0, 1'b0);
        run_frame(3'b111, 1'b0, 1'b0, 1'b0);
        pulse_step();
        run_frame(3'b111, 1'b0, 1'b0, 1'b0);
        run_frame(3'b111, 1'b0, 1'b0, 1'b0);
        // A step while unpaused must not arm.
        i_pause = 1'b0;
        pulse_step();
        i_pause = 1'b1;
        run_frame(3'b111, 1'b0, 1'b0, 1'b0);
        i_pause = 1'b0;
        // Pause rising mid-frame lets the frame finish.
        run_frame(3'b111, 1'b0, 1'b0, 1'b1);
        i_pause = 1'b0;

        for (int n = 0; n < 30; n++) random_frame(1'b1);

        // Reset while waiting on object 1.
        i_en = 3'b111; i_done = '0; i_animate = 1'b1;   // cycle 0
        tick(); i_animate = 1'b0;                        // cycle 1: ISSUE obj0
        tick(); i_animate = 1'b1;                        // cycle 2: WAIT, overrun
        tick(); i_animate = 1'b0; i_done = 3'b001;       // cycle 3: done obj0
        tick(); i_done = '0;                             // cycle 4: NEXT
        tick();                                          // cycle 5: ISSUE obj1
        @(negedge i_clk);
        check_eq("mr_stb1", 32'(o_ani_stb), 32'b010);
        tick(); i_rst = 1'b1;                            // cycle 6: WAIT obj1
        @(negedge i_clk);
        check_eq("mr_busy", 32'(o_busy), 32'd1);
        check_eq("mr_ovr",  32'(o_overrun), 32'd1);
        tick(); i_rst = 1'b0;                            // cycle 7: after reset
        @(negedge i_clk);
        check_eq("mr_post_stb",   32'(o_ani_stb), 32'd0);
        check_eq("mr_post_busy",  32'(o_busy),    32'd0);
        check_eq("mr_post_frame", 32'(o_frame),   32'd0);
        frame_m = 0; ov_m = 1'b0; to_m = 1'b0; step_m = 1'b0;
        check_flags("mr_post");
        tick();

        // Enough frames to wrap the 4-bit counter through 15 -> 0.
        for (int n = 0; n < 18; n++) random_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
